// File: rtl/noc_params.sv
// Shared router parameters and the port enumeration used across the NoC.
package noc_params;

   localparam int PORT_NUM = 5;
   localparam int VC_NUM   = 2;
   localparam int VC_SIZE  = $clog2(VC_NUM);

   // Router ports in index order; encodings 5..7 are not valid ports.
   typedef enum logic [2:0] {
      LOCAL = 3'd0,
      NORTH = 3'd1,
      SOUTH = 3'd2,
      WEST  = 3'd3,
      EAST  = 3'd4
   } port_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered priority
// pointer that moves past the winner whenever a grant is issued.
module round_robin_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] requests_i,
   output logic [N-1:0] grants_o
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW:0]   sum;
   logic [PW-1:0] idx;
   logic          found;

   // Search from the pointer upward (wrapping), first active request wins.
   always_comb begin
      grants_o = '0;
      ptr_d    = ptr_q;
      found    = 1'b0;
      sum      = '0;
      idx      = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr_q} + (PW+1)'(i);
         if (sum >= (PW+1)'(N)) begin
            sum = sum - (PW+1)'(N);
         end
         idx = sum[PW-1:0];
         if (!found && requests_i[idx]) begin
            found         = 1'b1;
            grants_o[idx] = 1'b1;
            ptr_d         = (idx == PW'(N-1)) ? '0 : idx + 1'b1;
         end
      end
   end

   // Pointer register; reset gives requester 0 the highest priority.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/vc_allocator.sv
// Virtual-channel allocator: per output port, one round-robin winner per
// cycle receives the lowest-index free downstream VC of that port.
module vc_allocator
   import noc_params::*;
(
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic  [PORT_NUM-1:0][VC_NUM-1:0]            request_i,
   input  port_t [PORT_NUM-1:0][VC_NUM-1:0]            out_port_i,
   input  logic  [PORT_NUM-1:0][VC_NUM-1:0]            idle_downstream_vc_i,
   output logic  [PORT_NUM-1:0][VC_NUM-1:0]            vc_valid_o,
   output logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] vc_new_o
);

   localparam int N_REQ = PORT_NUM * VC_NUM;

   logic [PORT_NUM-1:0][VC_NUM-1:0] avail_q, avail_d;
   logic [N_REQ-1:0]                pend_q, pend_d;
   logic [N_REQ-1:0]                valid_q, valid_d;
   logic [N_REQ-1:0][VC_SIZE-1:0]   new_q, new_d;

   logic [PORT_NUM-1:0][N_REQ-1:0]   cand;
   logic [PORT_NUM-1:0][N_REQ-1:0]   grant;
   logic [PORT_NUM-1:0][VC_SIZE-1:0] free_vc;

   // Candidate matrix and one arbiter per output port. Requesters granted
   // last cycle are masked so a still-high request is not served twice.
   for (genvar gp = 0; gp < PORT_NUM; gp++) begin : g_port
      for (genvar gr = 0; gr < N_REQ; gr++) begin : g_req
         assign cand[gp][gr] = request_i[gr / VC_NUM][gr % VC_NUM]
                            && (out_port_i[gr / VC_NUM][gr % VC_NUM] == port_t'(gp))
                            && !pend_q[gr]
                            && (|avail_q[gp]);
      end

      round_robin_arbiter #(
         .N (N_REQ)
      ) u_arb (
         .clk        (clk),
         .rst        (rst),
         .requests_i (cand[gp]),
         .grants_o   (grant[gp])
      );
   end

   // Lowest-index free VC of each output port (priority encoder).
   always_comb begin
      free_vc = '0;
      for (int p = 0; p < PORT_NUM; p++) begin
         for (int v = VC_NUM - 1; v >= 0; v--) begin
            if (avail_q[p][v]) begin
               free_vc[p] = VC_SIZE'(v);
            end
         end
      end
   end

   // Next state: apply releases, then claim the VC of each grant.
   always_comb begin
      avail_d = avail_q | idle_downstream_vc_i;
      valid_d = '0;
      new_d   = '0;
      pend_d  = '0;
      for (int p = 0; p < PORT_NUM; p++) begin
         for (int r = 0; r < N_REQ; r++) begin
            if (grant[p][r]) begin
               valid_d[r] = 1'b1;
               new_d[r]   = free_vc[p];
               pend_d[r]  = 1'b1;
            end
         end
         if (|grant[p]) begin
            avail_d[p][free_vc[p]] = 1'b0;
         end
      end
   end

   // State and output registers; reset frees every VC and drops grants.
   always_ff @(posedge clk) begin
      if (!rst) begin
         avail_q <= '1;
         pend_q  <= '0;
         valid_q <= '0;
         new_q   <= '0;
      end else begin
         avail_q <= avail_d;
         pend_q  <= pend_d;
         valid_q <= valid_d;
         new_q   <= new_d;
      end
   end

   assign vc_valid_o = valid_q;
   assign vc_new_o   = new_q;

endmodule
